// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe
//   Three-stage encoder from decoded posit form (sign / scale / wide fraction /
//   NaR / zero) to a packed NBITS-bit posit. Stage 1 normalizes the fraction with
//   a leading-zero count, stage 2 builds the regime/exponent/fraction string and
//   extracts guard/sticky, stage 3 applies round-to-nearest-even, clamps to
//   [minpos, maxpos] and negates.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid/in_ready    input stream handshake
//   in_sign, in_scale, in_fraction, in_inf, in_zero   decoded value
//                        (in_scale weights fraction bit MBITS-2)
//   out_valid/out_ready  output stream handshake
//   out_posit            encoded posit
module posit_encode_pipe #(
    parameter int NBITS = 32,
    parameter int ES    = 2,
    parameter int MBITS = 56,
    parameter int SBITS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [SBITS-1:0] in_scale,
    input  logic [MBITS-1:0] in_fraction,
    input  logic             in_inf,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_posit
);
    localparam int STAGES = 3;
    localparam int SW     = SBITS + 2;
    localparam int LZW    = $clog2(MBITS + 1);
    localparam int MAGW   = NBITS - 1;
    // {regime seed (2), exponent, fraction below hidden bit, NBITS of headroom}
    // The headroom keeps every shifted-out bit visible to the sticky OR.
    localparam int BW     = 2 + ES + (MBITS - 1) + NBITS;
    localparam logic signed [SW-1:0] KLIM = SW'(NBITS - 2);

    typedef struct packed {
        logic             sign;
        logic             inf;
        logic             zero;
        logic [SW-1:0]    scale;
        logic [MBITS-2:0] frac;   // bits below the leading one
    } norm_t;

    typedef struct packed {
        logic            sign;
        logic            inf;
        logic            zero;
        logic [MAGW-1:0] mag;
        logic            guard;
        logic            sticky;
    } body_t;

    logic [STAGES:1] vld_pipe;
    logic            advance;
    norm_t           s1_d, s1_q;
    body_t           s2_d, s2_q;
    logic [NBITS-1:0] res;

    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    // ---------------- stage 1: normalize ----------------
    logic [LZW-1:0] lz;

    always_comb begin
        lz = LZW'(MBITS);
        // ascending scan: the last hit is the highest set bit
        for (int i = 0; i < MBITS; i++)
            if (in_fraction[i]) lz = LZW'(MBITS - 1 - i);
    end

    always_comb begin
        s1_d.sign  = in_sign;
        s1_d.inf   = in_inf;
        s1_d.zero  = !in_inf && (in_zero || (in_fraction == '0));
        s1_d.scale = {{(SW-SBITS){in_scale[SBITS-1]}}, in_scale} + SW'(1) - SW'(lz);
        s1_d.frac  = (MBITS-1)'(in_fraction << lz);
    end

    // ---------------- stage 2: regime build ----------------
    logic signed [SW-1:0] sc, k;
    logic [SW-1:0]        sh;
    logic [BW-1:0]        base, shifted;
    logic                 sat_hi, sat_lo;

    always_comb begin
        sc      = $signed(s1_q.scale);
        k       = sc >>> ES;
        // Seed 10 replicates ones under arithmetic shift (k+1 ones, then 0);
        // seed 01 replicates zeros (-k zeros, then 1) with shift -k-1 = ~k.
        sh      = k[SW-1] ? ~k : k;
        base    = {(k[SW-1] ? 2'b01 : 2'b10), sc[ES-1:0], s1_q.frac, {NBITS{1'b0}}};
        shifted = $signed(base) >>> sh;
        sat_hi  = (k >= KLIM);
        sat_lo  = (k < -KLIM);

        s2_d.sign   = s1_q.sign;
        s2_d.inf    = s1_q.inf;
        s2_d.zero   = s1_q.zero;
        s2_d.mag    = sat_hi ? '1 : (sat_lo ? MAGW'(1) : shifted[BW-1 -: MAGW]);
        s2_d.guard  = !(sat_hi || sat_lo) && shifted[BW-NBITS];
        s2_d.sticky = !(sat_hi || sat_lo) && (|shifted[BW-NBITS-1:0]);
    end

    // ---------------- stage 3: round / sign ----------------
    logic             inc;
    logic [NBITS-1:0] sum, body;
    logic [MAGW-1:0]  rmag;

    always_comb begin
        inc  = s2_q.guard && (s2_q.mag[0] || s2_q.sticky);
        sum  = {1'b0, s2_q.mag} + NBITS'(inc);
        // rounding up from maxpos would carry into the sign bit: stay at maxpos
        rmag = sum[NBITS-1] ? '1 : sum[NBITS-2:0];
        body = {1'b0, rmag};
        if (s2_q.inf)       res = {1'b1, {(NBITS-1){1'b0}}};
        else if (s2_q.zero) res = '0;
        else if (s2_q.sign) res = -body;
        else                res = body;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            out_posit <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            if (vld_pipe[STAGES-1]) out_posit <= res;
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed bench for posit_encode_pipe: expected posits are queued on input
// acceptance and popped on each output handshake.
module tb_posit_encode_pipe;
    localparam int NBITS = 32;
    localparam int ES    = 2;
    localparam int MBITS = 56;
    localparam int SBITS = 9;

    localparam logic [MBITS-1:0] F_ONE = 56'h40000000000000; // 1.0 (bit 54)
    localparam logic [MBITS-1:0] F_TWO = 56'h80000000000000; // 2.0 (bit 55)
    localparam logic [MBITS-1:0] F_1P5 = 56'h60000000000000; // 1.5
    localparam logic [MBITS-1:0] F_LZ3 = 56'h10000000000000; // bit 52

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [SBITS-1:0] in_scale = '0;
    logic [MBITS-1:0] in_fraction = '0;
    logic             in_inf = 1'b0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [NBITS-1:0] out_posit;

    logic [NBITS-1:0] expq[$];
    int n_assert = 0;
    int n_fail   = 0;

    posit_encode_pipe #(.NBITS(NBITS), .ES(ES), .MBITS(MBITS), .SBITS(SBITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_scale(in_scale), .in_fraction(in_fraction),
        .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input int scale, input logic [MBITS-1:0] f,
                         input bit inf, input bit zero);
        in_sign     = s;
        in_scale    = scale[SBITS-1:0];
        in_fraction = f;
        in_inf      = inf;
        in_zero     = zero;
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic cyc(input logic [NBITS-1:0] exp_in, output bit acc);
        bit               stalled;
        logic [NBITS-1:0] held;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            else                  chk("out_posit", out_posit, expq.pop_front());
        end
        if (acc) expq.push_back(exp_in);
        stalled = out_valid && !out_ready;
        held    = out_posit;
        @(posedge clk);
        #1;
        if (stalled) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold", out_posit, held);
        end
    endtask

    task automatic send(input bit s, input int scale, input logic [MBITS-1:0] f,
                        input bit inf, input bit zero, input logic [NBITS-1:0] exp);
        bit acc;
        int n;
        drive(s, scale, f, inf, zero);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cyc(exp, acc);
            n++;
        end
        if (!acc) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        for (int n = 0; n < 20 && expq.size() > 0; n++) cyc('0, acc);
        if (expq.size() > 0) chk("drain_timeout", expq.size(), 32'd0);
    endtask

    // backpressure stream vectors
    bit               bs  [6] = '{0, 0, 0, 1, 0, 0};
    int               bsc [6] = '{0, 0, 0, 0, 200, -200};
    logic [MBITS-1:0] bf  [6] = '{F_ONE, F_TWO, F_1P5, F_ONE, F_ONE, F_ONE};
    logic [NBITS-1:0] bexp[6] = '{32'h40000000, 32'h48000000, 32'h44000000,
                                  32'hC0000000, 32'h7FFFFFFF, 32'h00000001};

    initial begin
        bit acc;
        int idx;
        logic [MBITS-1:0] f;

        // reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_posit", out_posit, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // latency: 1.0 appears exactly three edges after acceptance
        drive(0, 0, F_ONE, 0, 0);
        in_valid = 1'b1;
        cyc(32'h40000000, acc);
        chk("lat_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        cyc('0, acc);
        chk("lat_2", {31'd0, out_valid}, 32'd0);
        cyc('0, acc);
        chk("lat_3", {31'd0, out_valid}, 32'd1);
        drain();

        // normalization, sign, rounding, saturation, specials
        send(0, 0, F_TWO, 0, 0, 32'h48000000);
        send(0, 0, F_1P5, 0, 0, 32'h44000000);
        send(1, 0, F_ONE, 0, 0, 32'hC0000000);
        send(1, 0, F_1P5, 0, 0, 32'hBC000000);
        send(0, 2, F_LZ3, 0, 0, 32'h40000000);
        f = F_ONE | (56'd1 << 26);
        send(0, 0, f, 0, 0, 32'h40000000);            // tie -> even
        f = F_ONE | (56'd1 << 27) | (56'd1 << 26);
        send(0, 0, f, 0, 0, 32'h40000002);            // tie, odd lsb -> up
        f = F_ONE | (56'd1 << 26) | 56'd1;
        send(0, 0, f, 0, 0, 32'h40000001);            // above half -> up
        send(0, 116, F_ONE, 0, 0, 32'h7FFFFFFE);      // k = NBITS-3, last unsaturated
        send(0, 120, F_ONE, 0, 0, 32'h7FFFFFFF);      // k = NBITS-2 saturates
        send(0, 200, F_ONE, 0, 0, 32'h7FFFFFFF);
        send(0, -200, F_ONE, 0, 0, 32'h00000001);
        send(1, -200, F_ONE, 0, 0, 32'hFFFFFFFF);
        send(1, 0, F_ONE, 1, 1, 32'h80000000);        // NaR wins over zero
        send(1, 0, F_ONE, 0, 1, 32'h00000000);
        send(0, 5, '0, 0, 0, 32'h00000000);           // zero fraction
        drain();

        // backpressure: 6 beats back to back, out_ready low for 4 cycles
        idx = 0;
        for (int c = 0; c < 40 && (idx < 6 || expq.size() > 0); c++) begin
            out_ready = !(c >= 3 && c < 7);
            if (idx < 6) begin
                drive(bs[idx], bsc[idx], bf[idx], 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            cyc((idx < 6) ? bexp[idx] : '0, acc);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_sent", idx, 32'd6);
        chk("bp_all_out", expq.size(), 32'd0);

        // reset with three beats in flight
        send(0, 0, F_ONE, 0, 0, 32'h40000000);
        send(0, 0, F_TWO, 0, 0, 32'h48000000);
        send(0, 0, F_1P5, 0, 0, 32'h44000000);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_posit", out_posit, 32'd0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc('0, acc);
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        send(0, 0, F_TWO, 0, 0, 32'h48000000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
